// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA timing controller:
//   - 640x480@60 default timing constants
//   - line_total(): derives H_TOTAL / V_TOTAL from active + porches + sync
//   - max_int():    helper used to size the coordinate counters
//   - vga_state_e:  controller FSM state encoding
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE    = 640;
   localparam int DEF_H_FP        = 16;
   localparam int DEF_H_SYNC      = 96;
   localparam int DEF_H_BP        = 48;
   localparam int DEF_V_ACTIVE    = 480;
   localparam int DEF_V_FP        = 10;
   localparam int DEF_V_SYNC      = 2;
   localparam int DEF_V_BP        = 33;
   localparam bit DEF_H_POL       = 1'b0;
   localparam bit DEF_V_POL       = 1'b0;
   localparam int DEF_LOCK_CYCLES = 16;

   // Total clocks per line (or lines per frame) for one timing axis.
   function automatic int line_total(input int active, input int fp,
                                     input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2
   } vga_state_e;

endpackage

// File: rtl/vga_timing_ctrl_lock_qualifier.sv
// -----------------------------------------------------------------------------
// lock_qualifier
// Brings the asynchronous PLL lock flag into the pixel clock domain and
// measures how long it has been continuously asserted.
// Ports:
//   clk_pix   in  pixel clock
//   reset     in  synchronous active-high reset
//   locked    in  PLL lock, asynchronous to clk_pix
//   locked_s  out synchronized lock level
//   lock_ok   out lock has been stable long enough; the settle count reaches
//                 LOCK_CYCLES on this edge
//   lock_fall out one-cycle pulse on the first cycle locked_s reads 0
// -----------------------------------------------------------------------------
module lock_qualifier #(
   parameter int  LOCK_CYCLES = 16,
   localparam int SW          = $clog2(LOCK_CYCLES + 1)
) (
   input  logic clk_pix,
   input  logic reset,
   input  logic locked,
   output logic locked_s,
   output logic lock_ok,
   output logic lock_fall
);

   logic          sync_meta;
   logic          locked_d;
   logic [SW-1:0] settle_cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours; blocking here would
   // collapse the two synchronizer stages into one.
   always_ff @(posedge clk_pix) begin
      if (reset) begin
         sync_meta <= 1'b0;
         locked_s  <= 1'b0;
         locked_d  <= 1'b0;
      end else begin
         sync_meta <= locked;
         locked_s  <= sync_meta;
         locked_d  <= locked_s;
      end
   end

   // Counts consecutive cycles of synchronized lock and saturates, so the
   // count only restarts after lock has actually been lost.
   always_ff @(posedge clk_pix) begin
      if (reset || !locked_s) begin
         settle_cnt <= '0;
      end else if (settle_cnt != SW'(LOCK_CYCLES)) begin
         settle_cnt <= settle_cnt + 1'b1;
      end
   end

   // Asserted on the edge where the count steps to LOCK_CYCLES, so the FSM
   // enters RUN on the same edge.
   assign lock_ok   = locked_s && (settle_cnt >= SW'(LOCK_CYCLES - 1));
   assign lock_fall = locked_d && !locked_s;

endmodule

// File: rtl/vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl
// Lock-qualified VGA timing generator. Waits for a stable PLL lock, then runs
// horizontal/vertical counters and registered sync/DE/coordinate outputs. On
// loss of lock the display goes idle immediately and lock_lost is latched;
// after relock the raster restarts from frame origin.
// Ports:
//   clk_pix      in  pixel clock (sole clock)
//   reset        in  synchronous active-high reset
//   locked       in  PLL lock, asynchronous to clk_pix
//   hsync        out horizontal sync, active level H_POL
//   vsync        out vertical sync, active level V_POL
//   de           out active-video enable
//   x, y         out pixel column / row (0 outside RUN)
//   frame_start  out one-cycle pulse at x=0, y=0
//   running      out controller is in RUN
//   lock_lost    out sticky: lock dropped while running; cleared by reset
// -----------------------------------------------------------------------------
module vga_timing_ctrl
   import vga_timing_pkg::*;
#(
   parameter int  H_ACTIVE    = DEF_H_ACTIVE,
   parameter int  H_FP        = DEF_H_FP,
   parameter int  H_SYNC      = DEF_H_SYNC,
   parameter int  H_BP        = DEF_H_BP,
   parameter int  V_ACTIVE    = DEF_V_ACTIVE,
   parameter int  V_FP        = DEF_V_FP,
   parameter int  V_SYNC      = DEF_V_SYNC,
   parameter int  V_BP        = DEF_V_BP,
   parameter bit  H_POL       = DEF_H_POL,
   parameter bit  V_POL       = DEF_V_POL,
   parameter int  LOCK_CYCLES = DEF_LOCK_CYCLES,
   localparam int H_TOTAL     = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
   localparam int V_TOTAL     = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
   localparam int CW          = $clog2(max_int(H_TOTAL, V_TOTAL))
) (
   input  logic          clk_pix,
   input  logic          reset,
   input  logic          locked,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          frame_start,
   output logic          running,
   output logic          lock_lost
);

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

   vga_state_e    state, state_next;
   logic          locked_s, lock_ok, lock_fall;
   logic          run_active;
   logic [CW-1:0] hc, vc;

   lock_qualifier #(
      .LOCK_CYCLES (LOCK_CYCLES)
   ) u_lock_qualifier (
      .clk_pix   (clk_pix),
      .reset     (reset),
      .locked    (locked),
      .locked_s  (locked_s),
      .lock_ok   (lock_ok),
      .lock_fall (lock_fall)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk_pix) begin
      if (reset) state <= WAIT_LOCK;
      else       state <= state_next;
   end

   // NOTE: next state gets a default before the case so every path assigns
   // it; a missing default here would infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         WAIT_LOCK: if (locked_s) state_next = SETTLE;
         SETTLE: begin
            if (!locked_s)    state_next = WAIT_LOCK;
            else if (lock_ok) state_next = RUN;
         end
         RUN:       if (lock_fall) state_next = WAIT_LOCK;
         default:   state_next = WAIT_LOCK;
      endcase
   end

   // Lock loss overrides the counter advance and output decode on the same
   // edge the FSM leaves RUN, so the display goes dark without a stray pixel.
   assign run_active = (state == RUN) && !lock_fall;

   // ---------------- raster counters ----------------
   always_ff @(posedge clk_pix) begin
      if (reset || !run_active) begin
         hc <= '0;
         vc <= '0;
      end else if (hc == H_LAST) begin
         hc <= '0;
         vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
         hc <= hc + 1'b1;
      end
   end

   // ---------------- registered output decode ----------------
   always_ff @(posedge clk_pix) begin
      if (reset || !run_active) begin
         hsync       <= ~H_POL;
         vsync       <= ~V_POL;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         frame_start <= 1'b0;
         running     <= 1'b0;
      end else begin
         hsync       <= (hc >= HS_FIRST && hc <= HS_LAST) ? H_POL : ~H_POL;
         vsync       <= (vc >= VS_FIRST && vc <= VS_LAST) ? V_POL : ~V_POL;
         de          <= (hc < H_ACT) && (vc < V_ACT);
         x           <= hc;
         y           <= vc;
         frame_start <= (hc == '0) && (vc == '0);
         running     <= 1'b1;
      end
   end

   always_ff @(posedge clk_pix) begin
      if (reset)                          lock_lost <= 1'b0;
      else if (state == RUN && lock_fall) lock_lost <= 1'b1;
   end

endmodule
